// File: rtl/multicycle_control_unit.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer for the RISC core.
// Define CU_STACK_EN to enable JAL push, RET pop and stop_bit returns through the stack.
module multicycle_control_unit #(
  parameter int unsigned FUNC_W      = 5,
  parameter int unsigned OP_W        = 2,
  parameter int unsigned ALUOP_W     = 4,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [OP_W-1:0]    op,
  input  logic [FUNC_W-1:0]  func,
  input  logic               stop_bit,
  input  logic               zero,
  input  logic               mem_ready,
  input  logic               stack_empty,
  output logic [1:0]         PCSrc,
  output logic               pc_wr,
  output logic               ir_wr,
  output logic               StackRd,
  output logic               StackWr,
  output logic               RegWr,
  output logic               RegSrc,
  output logic               ExtOp,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic [1:0]         ALUSrc,
  output logic               MemRd,
  output logic               MemWr,
  output logic               WBData,
  output logic [2:0]         state,
  output logic               illegal,
  output logic               bus_err
);

  localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  typedef enum logic [4:0] {
    I_AND, I_ADD, I_SUB, I_CMP, I_J, I_JAL, I_RET, I_ANDI, I_ADDI,
    I_LW, I_SW, I_BEQ, I_SLL, I_SRL, I_SLLV, I_SRLV, I_ILL
  } ins_t;

  state_t           r_state;
  ins_t             r_ins;
  logic             r_stop;
  logic [CNT_W-1:0] r_wait;
  ins_t             w_dec_ins;
  logic             w_stop;
  logic             w_timeout;
  logic             w_fin;
  logic [1:0]       w_sel;

  // Map raw IR fields onto one instruction code; anything undefined is I_ILL.
  function automatic ins_t classify(input logic [OP_W-1:0] o, input logic [FUNC_W-1:0] f);
    ins_t r;
    r = I_ILL;
    if ((o >> 2) == '0) begin
      case (o[1:0])
        2'd0: case (f)
          FUNC_W'(0): r = I_AND;
          FUNC_W'(1): r = I_ADD;
          FUNC_W'(2): r = I_SUB;
          FUNC_W'(3): r = I_CMP;
          default:    r = I_ILL;
        endcase
        2'd1: case (f)
          FUNC_W'(0): r = I_J;
`ifdef CU_STACK_EN
          FUNC_W'(1): r = I_JAL;
          FUNC_W'(2): r = I_RET;
`else
          FUNC_W'(1): r = I_J;
`endif
          default:    r = I_ILL;
        endcase
        2'd2: case (f)
          FUNC_W'(0): r = I_ANDI;
          FUNC_W'(1): r = I_ADDI;
          FUNC_W'(2): r = I_LW;
          FUNC_W'(3): r = I_SW;
          FUNC_W'(4): r = I_BEQ;
          default:    r = I_ILL;
        endcase
        default: case (f)
          FUNC_W'(0): r = I_SLL;
          FUNC_W'(1): r = I_SRL;
          FUNC_W'(2): r = I_SLLV;
          FUNC_W'(3): r = I_SRLV;
          default:    r = I_ILL;
        endcase
      endcase
    end
    return r;
  endfunction

  assign w_dec_ins = classify(op, func);
  assign w_timeout = (r_wait == CNT_W'(MEM_TIMEOUT));
  assign state     = r_state;

`ifdef CU_STACK_EN
  assign w_stop = stop_bit;
`else
  logic w_unused;
  assign w_stop   = 1'b0;
  assign w_unused = stop_bit;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_FETCH;
      r_ins   <= I_ILL;
      r_stop  <= 1'b0;
      r_wait  <= '0;
    end else begin
      case (r_state)
        S_FETCH: r_state <= S_DECODE;
        S_DECODE: begin
          r_ins  <= w_dec_ins;
          r_stop <= w_stop;
          case (w_dec_ins)
            I_J, I_JAL, I_RET, I_ILL: r_state <= S_FETCH;
            default:                  r_state <= S_EXEC;
          endcase
        end
        S_EXEC: begin
          r_wait <= '0;
          case (r_ins)
            I_LW, I_SW: r_state <= S_MEM;
            I_BEQ:      r_state <= S_FETCH;
            default:    r_state <= S_WB;
          endcase
        end
        S_MEM: begin
          if (mem_ready)      r_state <= (r_ins == I_LW) ? S_WB : S_FETCH;
          else if (w_timeout) r_state <= S_FETCH;
          else                r_wait  <= r_wait + CNT_W'(1);
        end
        default: r_state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    ir_wr   = 1'b0;
    pc_wr   = 1'b0;
    PCSrc   = 2'b00;
    StackRd = 1'b0;
    StackWr = 1'b0;
    RegWr   = 1'b0;
    RegSrc  = 1'b0;
    ExtOp   = 1'b0;
    ALUOp   = '0;
    ALUSrc  = 2'b00;
    MemRd   = 1'b0;
    MemWr   = 1'b0;
    WBData  = 1'b0;
    illegal = 1'b0;
    bus_err = 1'b0;
    w_fin   = 1'b0;
    w_sel   = 2'b00;
    // Datapath selects track the latched instruction from EXEC onward.
    if (r_state == S_EXEC || r_state == S_MEM || r_state == S_WB) begin
      case (r_ins)
        I_AND:        ALUOp = ALUOP_W'(2);
        I_SUB, I_CMP: ALUOp = ALUOP_W'(1);
        I_ANDI:       begin ALUOp = ALUOP_W'(2); ALUSrc = 2'b01; end
        I_ADDI, I_LW: begin ALUSrc = 2'b01; ExtOp = 1'b1; end
        I_SW:         begin ALUSrc = 2'b01; ExtOp = 1'b1; RegSrc = 1'b1; end
        I_BEQ:        begin ALUOp = ALUOP_W'(1); ExtOp = 1'b1; RegSrc = 1'b1; end
        I_SLL:        begin ALUOp = ALUOP_W'(3); ALUSrc = 2'b10; end
        I_SRL:        begin ALUOp = ALUOP_W'(4); ALUSrc = 2'b10; end
        I_SLLV:       ALUOp = ALUOP_W'(3);
        I_SRLV:       ALUOp = ALUOP_W'(4);
        default:      ;
      endcase
    end
    case (r_state)
      S_FETCH: ir_wr = 1'b1;
      S_DECODE: begin
        case (w_dec_ins)
          I_J:   begin pc_wr = 1'b1; PCSrc = 2'b10; end
          I_JAL: begin pc_wr = 1'b1; PCSrc = 2'b10; StackWr = 1'b1; end
          I_RET: begin
            pc_wr = 1'b1;
            if (stack_empty) illegal = 1'b1;
            else begin PCSrc = 2'b11; StackRd = 1'b1; end
          end
          I_ILL: begin pc_wr = 1'b1; illegal = 1'b1; end
          default: ;
        endcase
      end
      S_EXEC: begin
        if (r_ins == I_BEQ) begin
          w_fin = 1'b1;
          w_sel = zero ? 2'b01 : 2'b00;
        end
      end
      S_MEM: begin
        // A ready in the timeout cycle still completes the access.
        if (mem_ready || !w_timeout) begin
          MemRd = (r_ins == I_LW);
          MemWr = (r_ins == I_SW);
        end
        if (mem_ready && r_ins == I_SW) w_fin = 1'b1;
        if (!mem_ready && w_timeout) begin
          bus_err = 1'b1;
          pc_wr   = 1'b1;
        end
      end
      S_WB: begin
        RegWr  = (r_ins != I_CMP);
        WBData = (r_ins == I_LW);
        w_fin  = 1'b1;
      end
      default: ;
    endcase
    if (w_fin) begin
      pc_wr = 1'b1;
      if (r_stop) begin
        if (stack_empty) illegal = 1'b1;
        else begin PCSrc = 2'b11; StackRd = 1'b1; end
      end else begin
        PCSrc = w_sel;
      end
    end
`ifndef CU_STACK_EN
    StackRd = 1'b0;
    StackWr = 1'b0;
`endif
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomised self-checking bench for multicycle_control_unit against a per-instruction cycle model.
module tb_multicycle_control_unit;
  localparam int unsigned FW = 5, OW = 2, AW = 4, MTO = 15;

  logic clk = 1'b0;
  logic reset;
  logic [OW-1:0] op;
  logic [FW-1:0] func;
  logic stop_bit, zero, mem_ready, stack_empty;
  logic [1:0] PCSrc, ALUSrc;
  logic pc_wr, ir_wr, StackRd, StackWr, RegWr, RegSrc, ExtOp;
  logic [AW-1:0] ALUOp;
  logic MemRd, MemWr, WBData, illegal, bus_err;
  logic [2:0] state;

  multicycle_control_unit #(.FUNC_W(FW), .OP_W(OW), .ALUOP_W(AW), .MEM_TIMEOUT(MTO)) dut (
    .clk(clk), .reset(reset), .op(op), .func(func), .stop_bit(stop_bit), .zero(zero),
    .mem_ready(mem_ready), .stack_empty(stack_empty), .PCSrc(PCSrc), .pc_wr(pc_wr),
    .ir_wr(ir_wr), .StackRd(StackRd), .StackWr(StackWr), .RegWr(RegWr), .RegSrc(RegSrc),
    .ExtOp(ExtOp), .ALUOp(ALUOp), .ALUSrc(ALUSrc), .MemRd(MemRd), .MemWr(MemWr),
    .WBData(WBData), .state(state), .illegal(illegal), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st; logic ir_wr; logic pc_wr; logic [1:0] pcsrc; logic srd; logic swr;
    logic regwr; logic regsrc; logic extop; logic [3:0] aluop; logic [1:0] alusrc;
    logic memrd; logic memwr; logic wbdata; logic ill; logic berr;
  } exp_t;
  typedef struct packed { logic [1:0] op; logic [4:0] func; logic zero; logic rdy; } drv_t;

  exp_t exp_q[$];
  drv_t drv_q[$];
  int   total = 0, bad = 0;
  bit   chk_en = 1'b0;
  int   cur_len = 0, n_regwr = 0, last_pcsrc = 0, mlen = 0;
  bit   f_wbdata, f_berr, f_ill, f_swr, f_srd;
`ifdef CU_STACK_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif

  task automatic check(input string name, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, want);
    end
  endtask

  task automatic push(input exp_t e, input int o, input int f, input bit z, input bit r);
    drv_t d;
    exp_q.push_back(e);
    d.op = 2'(o); d.func = 5'(f); d.zero = z; d.rdy = r;
    drv_q.push_back(d);
  endtask

  // Instruction table: cls -1 illegal, 0 ALU, 1 LW, 2 SW, 3 BEQ, 4 J, 5 JAL, 6 RET.
  task automatic classify(input int o, input int f, output int cls, output bit wr, output exp_t dp);
    cls = 0; wr = 1'b1; dp = '0;
    case (o)
      0: case (f)
        0: dp.aluop = 4'd2;
        1: ;
        2: dp.aluop = 4'd1;
        3: begin dp.aluop = 4'd1; wr = 1'b0; end
        default: cls = -1;
      endcase
      1: case (f)
        0: cls = 4;
        1: cls = STK ? 5 : 4;
        2: cls = STK ? 6 : -1;
        default: cls = -1;
      endcase
      2: case (f)
        0: begin dp.aluop = 4'd2; dp.alusrc = 2'd1; end
        1: begin dp.alusrc = 2'd1; dp.extop = 1'b1; end
        2: begin cls = 1; dp.alusrc = 2'd1; dp.extop = 1'b1; end
        3: begin cls = 2; dp.alusrc = 2'd1; dp.extop = 1'b1; dp.regsrc = 1'b1; wr = 1'b0; end
        4: begin cls = 3; dp.aluop = 4'd1; dp.extop = 1'b1; dp.regsrc = 1'b1; wr = 1'b0; end
        default: cls = -1;
      endcase
      3: case (f)
        0: begin dp.aluop = 4'd3; dp.alusrc = 2'd2; end
        1: begin dp.aluop = 4'd4; dp.alusrc = 2'd2; end
        2: dp.aluop = 4'd3;
        3: dp.aluop = 4'd4;
        default: cls = -1;
      endcase
      default: cls = -1;
    endcase
  endtask

  function automatic exp_t fin(input exp_t e0, input int sel, input bit stp, input bit se);
    exp_t e = e0;
    e.pc_wr = 1'b1;
    if (stp) begin
      if (se) e.ill = 1'b1;
      else begin e.pcsrc = 2'd3; e.srd = 1'b1; end
    end else e.pcsrc = 2'(sel);
    return e;
  endfunction

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Builds the expected per-cycle outputs and the inputs to drive for one instruction.
  task automatic model(input int o, input int f, input bit stop, input bit z, input bit se, input int delay);
    int cls; bit wr; exp_t dp, e; bit stp;
    stp = stop && STK;
    classify(o, f, cls, wr, dp);
    e = '0; e.ir_wr = 1'b1;
    push(e, $urandom_range(0, 3), $urandom_range(0, 31), rb(), rb());
    e = '0; e.st = 3'd1;
    if (cls < 0) begin e.pc_wr = 1'b1; e.ill = 1'b1; push(e, o, f, rb(), rb()); return; end
    if (cls == 4 || cls == 5) begin
      e.pc_wr = 1'b1; e.pcsrc = 2'd2; e.swr = (cls == 5);
      push(e, o, f, rb(), rb()); return;
    end
    if (cls == 6) begin
      e.pc_wr = 1'b1;
      if (se) e.ill = 1'b1; else begin e.pcsrc = 2'd3; e.srd = 1'b1; end
      push(e, o, f, rb(), rb()); return;
    end
    push(e, o, f, rb(), rb());
    e = dp; e.st = 3'd2;
    if (cls == 3) begin push(fin(e, z ? 1 : 0, stp, se), o, f, z, rb()); return; end
    push(e, o, f, z, rb());
    if (cls == 1 || cls == 2) begin
      for (int w = 0; w <= int'(MTO); w++) begin
        e = dp; e.st = 3'd3;
        if (w == delay) begin
          e.memrd = (cls == 1); e.memwr = (cls == 2);
          if (cls == 2) begin push(fin(e, 0, stp, se), o, f, rb(), 1'b1); return; end
          push(e, o, f, rb(), 1'b1);
          break;
        end else if (w == int'(MTO)) begin
          e.berr = 1'b1; e.pc_wr = 1'b1;
          push(e, o, f, rb(), 1'b0); return;
        end else begin
          e.memrd = (cls == 1); e.memwr = (cls == 2);
          push(e, o, f, rb(), 1'b0);
        end
      end
    end
    e = dp; e.st = 3'd4; e.regwr = wr; e.wbdata = (cls == 1);
    push(fin(e, 0, stp, se), o, f, rb(), rb());
  endtask

  // Called at the start of a FETCH cycle; returns at the start of the next FETCH.
  task automatic run_instr(input int o, input int f, input bit stp, input bit z, input bit se, input int delay);
    drv_t d; int n;
    n = exp_q.size();
    model(o, f, stp, z, se, delay);
    n = exp_q.size() - n;
    mlen = n;
    stop_bit = stp; stack_empty = se;
    for (int i = 0; i < n; i++) begin
      if (i != 0) begin @(posedge clk); #1; end
      d = drv_q.pop_front();
      op = d.op; func = d.func; zero = d.zero; mem_ready = d.rdy;
    end
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin : cmp
    exp_t a, e;
    if (chk_en) begin
      a.st = state; a.ir_wr = ir_wr; a.pc_wr = pc_wr; a.pcsrc = PCSrc; a.srd = StackRd;
      a.swr = StackWr; a.regwr = RegWr; a.regsrc = RegSrc; a.extop = ExtOp; a.aluop = ALUOp;
      a.alusrc = ALUSrc; a.memrd = MemRd; a.memwr = MemWr; a.wbdata = WBData;
      a.ill = illegal; a.berr = bus_err;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL cycle_cmp t=%0t: no expectation queued, got=%h", $time, a);
      end else begin
        e = exp_q.pop_front();
        if (a !== e) begin
          bad++;
          $display("FAIL cycle_cmp t=%0t state=%0d: got=%h want=%h", $time, state, a, e);
        end
      end
      if (state == 3'd0) begin
        cur_len = 1; n_regwr = 0;
        f_wbdata = 0; f_berr = 0; f_ill = 0; f_swr = 0; f_srd = 0;
      end else cur_len++;
      if (RegWr) n_regwr++;
      if (WBData) f_wbdata = 1;
      if (bus_err) f_berr = 1;
      if (illegal) f_ill = 1;
      if (StackWr) f_swr = 1;
      if (StackRd) f_srd = 1;
      if (pc_wr) last_pcsrc = int'(PCSrc);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; op = '0; func = '0; stop_bit = 1'b0; zero = 1'b0;
    mem_ready = 1'b0; stack_empty = 1'b0;
    #3;
    check("rst_state", int'(state), 0);
    check("rst_ir_wr", int'(ir_wr), 1);
    check("rst_pc_wr", int'(pc_wr), 0);
    check("rst_memrd", int'(MemRd), 0);
    check("rst_regwr", int'(RegWr), 0);
    @(posedge clk); #1;
    reset = 1'b1; chk_en = 1'b1;

    run_instr(0, 1, 0, 0, 0, 0);
    check("add_len", cur_len, 4);
    check("add_model_len", mlen, 4);
    check("add_regwr_cycles", n_regwr, 1);
    check("add_pcsrc", last_pcsrc, 0);
    run_instr(2, 4, 0, 1, 0, 0);
    check("beq_z1_len", cur_len, 3);
    check("beq_z1_pcsrc", last_pcsrc, 1);
    run_instr(2, 4, 0, 0, 0, 0);
    check("beq_z0_len", cur_len, 3);
    check("beq_z0_pcsrc", last_pcsrc, 0);
    run_instr(2, 2, 0, 0, 0, 3);
    check("lw_wait3_len", cur_len, 8);
    check("lw_wait3_model_len", mlen, 8);
    check("lw_wbdata", int'(f_wbdata), 1);
    run_instr(2, 2, 0, 0, 0, 99);
    check("lw_timeout_len", cur_len, 19);
    check("lw_timeout_buserr", int'(f_berr), 1);
    check("lw_timeout_regwr", n_regwr, 0);
    run_instr(2, 3, 0, 0, 0, 15);
    check("sw_ready_at_limit_len", cur_len, 19);
    check("sw_ready_at_limit_buserr", int'(f_berr), 0);
    run_instr(1, 1, 0, 0, 0, 0);
    check("jal_len", cur_len, 2);
    check("jal_pcsrc", last_pcsrc, 2);
    check("jal_stackwr", int'(f_swr), STK ? 1 : 0);
    run_instr(1, 2, 0, 0, 0, 0);
    check("ret_len", cur_len, 2);
    check("ret_pcsrc", last_pcsrc, STK ? 3 : 0);
    check("ret_stackrd", int'(f_srd), STK ? 1 : 0);
    check("ret_illegal", int'(f_ill), STK ? 0 : 1);
    run_instr(1, 2, 0, 0, 1, 0);
    check("ret_empty_illegal", int'(f_ill), 1);
    check("ret_empty_pcsrc", last_pcsrc, 0);
    run_instr(0, 7, 0, 0, 0, 0);
    check("ill_len", cur_len, 2);
    check("ill_pulse", int'(f_ill), 1);
    run_instr(0, 1, 1, 0, 0, 0);
    check("stop_add_pcsrc", last_pcsrc, STK ? 3 : 0);

    for (int k = 0; k < 300; k++) begin
      int o, f, dl; bit s, z, se;
      o  = $urandom_range(0, 3);
      f  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 4);
      s  = ($urandom_range(0, 3) == 0);
      se = ($urandom_range(0, 3) == 0);
      z  = rb();
      case ($urandom_range(0, 9))
        0:       dl = int'(MTO);
        1:       dl = 99;
        2:       dl = int'(MTO) - 1;
        default: dl = $urandom_range(0, 4);
      endcase
      run_instr(o, f, s, z, se, dl);
    end
    check("queue_drained", exp_q.size(), 0);

    // Asynchronous reset while a load sits in MEM.
    chk_en = 1'b0;
    op = 2'd2; func = 5'd2; stop_bit = 1'b0; stack_empty = 1'b0; mem_ready = 1'b0;
    @(posedge clk); @(posedge clk); @(posedge clk); #2;
    check("mid_mem_state", int'(state), 3);
    check("mid_mem_memrd", int'(MemRd), 1);
    reset = 1'b0;
    #1;
    check("async_rst_state", int'(state), 0);
    check("async_rst_memrd", int'(MemRd), 0);
    check("async_rst_ir_wr", int'(ir_wr), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
